// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_pkg
//  Purpose  : Shared constants and types for the instruction-fetch front end:
//             enable levels, the fetch state encoding and the FIFO entry.
//  Revision : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b1;
  localparam logic        StallEnable = 1'b1;
  localparam logic        FlushEnable = 1'b1;
  localparam logic [31:0] PcIncr      = 32'd4;

  // IDLE: nothing outstanding; REQ: request on the bus;
  // DISCARD: a squashed request is still outstanding and its data is dropped.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_if
//  Purpose  : Bundles the pipeline-control, instruction-memory and IF/ID
//             signals of the fetch unit. master = fetch unit, slave = the
//             surrounding pipeline and memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  modport master (
    input  stall, flush, redirect_pc, imem_ready, imem_rdata,
    output imem_req, imem_addr, if_pc, if_inst, if_valid
  );

  modport slave (
    output stall, flush, redirect_pc, imem_ready, imem_rdata,
    input  imem_req, imem_addr, if_pc, if_inst, if_valid
  );
endinterface
`default_nettype wire

// File: rtl/if_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : if_skid_fifo
//  Purpose  : DEPTH-entry {pc, inst} FIFO with a combinationally visible head.
//             clear_i empties it at the edge and overrides push/pop.
//  Revision : 1.0 - initial release
// ============================================================================
module if_skid_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear_i,
  input  wire logic             push_i,
  input  wire logic             pop_i,
  input  wire fetch_entry_t     push_data_i,
  output fetch_entry_t          head_o,
  output logic                  valid_o,
  output logic [CNT_W-1:0]      cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  always_comb begin
    w_full    = (cnt_q == c_full_cnt);
    w_do_pop  = pop_i & (cnt_q != '0);
    w_do_push = push_i & (~w_full | w_do_pop);
  end

  // Pointer and occupancy bookkeeping; clear behaves like a reset.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (cnt_q != '0);
  assign cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Purpose  : Instruction-fetch front end. Issues sequential single-outstanding
//             fetches, buffers responses in a skid FIFO for the IF/ID register
//             and squashes the in-flight path on flush.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  if_fetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] c_room_max = (CNT_W + 1)'(DEPTH - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;

  logic             w_flush;
  logic             w_pop;
  logic             w_push;
  logic             w_room;
  logic             w_fifo_valid;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W:0]   w_cnt_next;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;

  // Handshake terms; room looks at the occupancy after this cycle's push/pop
  // so a new request is only issued when its response is sure to fit.
  always_comb begin
    w_flush      = (bus.flush == FlushEnable);
    w_pop        = w_fifo_valid & (bus.stall != StallEnable) & ~w_flush;
    w_push       = (state_q == REQ) & bus.imem_ready & ~w_flush;
    w_cnt_next   = {1'b0, w_cnt} + (CNT_W + 1)'(w_push) - (CNT_W + 1)'(w_pop);
    w_room       = (w_cnt_next <= c_room_max);
    w_push_entry = '{pc: fetch_pc_q, inst: bus.imem_rdata};
  end

  // Fetch state and PC registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      IDLE: begin
        if (w_flush)     fetch_pc_d = bus.redirect_pc;
        else if (w_room) state_d    = REQ;
      end
      REQ: begin
        if (w_flush) begin
          // The squashed request either completes now (data dropped) or is
          // still outstanding and must be drained in DISCARD.
          fetch_pc_d = bus.redirect_pc;
          state_d    = bus.imem_ready ? IDLE : DISCARD;
        end else if (bus.imem_ready) begin
          fetch_pc_d = fetch_pc_q + PcIncr;
          state_d    = w_room ? REQ : IDLE;
        end
      end
      DISCARD: begin
        // A repeated flush only retargets; the drain still ends on imem_ready.
        if (w_flush)        fetch_pc_d = bus.redirect_pc;
        if (bus.imem_ready) state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  if_skid_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_skid_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (w_flush),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .push_data_i (w_push_entry),
    .head_o      (w_head),
    .valid_o     (w_fifo_valid),
    .cnt_o       (w_cnt)
  );

  assign bus.imem_req  = (state_q == REQ);
  assign bus.imem_addr = fetch_pc_q;
  assign bus.if_valid  = w_fifo_valid;
  assign bus.if_pc     = w_fifo_valid ? w_head.pc   : ZeroWord;
  assign bus.if_inst   = w_fifo_valid ? w_head.inst : ZeroWord;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch
//  Purpose  : Directed self-checking bench for if_fetch. A small memory model
//             answers requests after a programmable latency with
//             rdata = 0xA0000001 + addr; flush scenarios drive the memory by hand.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit mem_en = 1'b0;
  int mem_lat = 0;
  int wait_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0001 + a;
  endfunction

  // Advance one clock; the memory model updates just after the edge and
  // outputs are sampled 2 time units after the edge.
  task automatic step();
    logic prev_req;
    logic prev_done;
    prev_req  = bus.imem_req;
    prev_done = bus.imem_req & bus.imem_ready;
    @(posedge clk);
    #1;
    if (mem_en) begin
      if (!bus.imem_req || !prev_req || prev_done) wait_cnt = 0;
      else wait_cnt++;
      bus.imem_ready = bus.imem_req && (wait_cnt == mem_lat);
      bus.imem_rdata = bus.imem_ready ? mem_word(bus.imem_addr) : 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_pc = 32'h0;
    mem_en = 1'b0; bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b want 0", bus.imem_req); end
    n_vec++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", bus.if_valid); end
    n_vec++; if (bus.if_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", bus.if_pc); end
    n_vec++; if (bus.if_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h want 0", bus.if_inst); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_en = 1'b1; mem_lat = 0;
    step();
    n_vec++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL stream_first_req: got %0b want 1", bus.imem_req); end
    n_vec++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL stream_first_addr: got %h want 0", bus.imem_addr); end
    n_vec++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL stream_first_valid: got %0b want 0", bus.if_valid); end
    for (int c = 2; c <= 8; c++) begin
      logic [31:0] epc;
      logic [31:0] eaddr;
      step();
      epc   = 32'(4 * (c - 2));
      eaddr = 32'(4 * (c - 1));
      n_vec++; if (bus.if_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid c%0d: got %0b want 1", c, bus.if_valid); end
      n_vec++; if (bus.if_pc !== epc) begin n_err++; $display("FAIL stream_pc c%0d: got %h want %h", c, bus.if_pc, epc); end
      n_vec++; if (bus.if_inst !== 32'hA000_0001 + epc) begin n_err++; $display("FAIL stream_inst c%0d: got %h want %h", c, bus.if_inst, 32'hA000_0001 + epc); end
      n_vec++; if (bus.imem_addr !== eaddr) begin n_err++; $display("FAIL stream_addr c%0d: got %h want %h", c, bus.imem_addr, eaddr); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    mem_en = 1'b1; mem_lat = 0;
    step(); step(); step();          // head pc 4, request for 8 answered now
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req k%0d: got %0b want 0", k, bus.imem_req); end
      n_vec++; if (bus.if_pc !== 32'h4) begin n_err++; $display("FAIL stall_head k%0d: got %h want 4", k, bus.if_pc); end
    end
    bus.stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] epc;
      step();
      epc = 32'(8 + 4 * k);
      n_vec++; if (bus.if_pc !== epc || bus.if_valid !== 1'b1) begin n_err++; $display("FAIL stall_resume k%0d: got pc %h valid %0b want %h 1", k, bus.if_pc, bus.if_valid, epc); end
    end
  endtask

  task automatic test_latency();
    do_reset();
    mem_en = 1'b1; mem_lat = 3;
    for (int c = 1; c <= 9; c++) begin
      logic        ev;
      logic [31:0] eaddr;
      step();
      ev    = (c == 5) || (c == 9);
      eaddr = (c <= 4) ? 32'h0 : (c <= 8) ? 32'h4 : 32'h8;
      n_vec++; if (bus.imem_addr !== eaddr) begin n_err++; $display("FAIL lat_addr c%0d: got %h want %h", c, bus.imem_addr, eaddr); end
      n_vec++; if (bus.if_valid !== ev) begin n_err++; $display("FAIL lat_valid c%0d: got %0b want %0b", c, bus.if_valid, ev); end
      if (c == 9) begin
        n_vec++; if (bus.if_pc !== 32'h4) begin n_err++; $display("FAIL lat_pc: got %h want 4", bus.if_pc); end
      end
    end
  endtask

  task automatic test_flush_pending();
    do_reset();
    step();                                   // REQ for 0x0, no response yet
    bus.flush = 1'b1; bus.redirect_pc = 32'h100;
    step();                                   // -> DISCARD
    bus.flush = 1'b0;
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL fp_discard_req: got %0b want 0", bus.imem_req); end
    step();
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0000_DEAD;
    step();                                   // stale data dropped -> IDLE
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    n_vec++; if (bus.if_valid !== 1'b0 || bus.if_inst !== 32'h0) begin n_err++; $display("FAIL fp_dropped: got valid %0b inst %h want 0 00000000", bus.if_valid, bus.if_inst); end
    step();
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL fp_redirect: got req %0b addr %h want 1 00000100", bus.imem_req, bus.imem_addr); end
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'hC0DE_0100;
    step();
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    n_vec++; if (bus.if_pc !== 32'h100 || bus.if_inst !== 32'hC0DE_0100) begin n_err++; $display("FAIL fp_new_head: got %h/%h want 00000100/c0de0100", bus.if_pc, bus.if_inst); end
    n_vec++; if (bus.imem_addr !== 32'h104) begin n_err++; $display("FAIL fp_next_addr: got %h want 00000104", bus.imem_addr); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    mem_en = 1'b1; mem_lat = 0;
    step(); step(); step();                   // FIFO holds pc 4, ready for 8 now
    bus.flush = 1'b1; bus.stall = 1'b1; bus.redirect_pc = 32'h200;
    step();
    bus.flush = 1'b0;
    n_vec++; if (bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_inst !== 32'h0) begin n_err++; $display("FAIL fs_empty: got valid %0b pc %h inst %h want 0", bus.if_valid, bus.if_pc, bus.if_inst); end
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL fs_req_idle: got %0b want 0", bus.imem_req); end
    step();
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin n_err++; $display("FAIL fs_restart: got req %0b addr %h want 1 00000200", bus.imem_req, bus.imem_addr); end
    step();
    n_vec++; if (bus.if_pc !== 32'h200 || bus.if_inst !== 32'hA000_0201) begin n_err++; $display("FAIL fs_head: got %h/%h want 00000200/a0000201", bus.if_pc, bus.if_inst); end
    bus.stall = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    bus.flush = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.flush = 1'b0;
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL wrap_idle_flush: got %0b want 0", bus.imem_req); end
    step();
    n_vec++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h want fffffffc", bus.imem_addr); end
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1111_1111;
    step();
    n_vec++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next: got %h want 00000000", bus.imem_addr); end
    n_vec++; if (bus.if_pc !== 32'hFFFF_FFFC || bus.if_inst !== 32'h1111_1111) begin n_err++; $display("FAIL wrap_head: got %h/%h want fffffffc/11111111", bus.if_pc, bus.if_inst); end
    rst = 1'b1; bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    step();
    n_vec++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0) begin n_err++; $display("FAIL midreq_rst: got req %0b valid %0b pc %h want 0 0 0", bus.imem_req, bus.if_valid, bus.if_pc); end
    rst = 1'b0;
    step();
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_restart: got req %0b addr %h want 1 00000000", bus.imem_req, bus.imem_addr); end
  endtask

  initial begin
    rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_pc = 32'h0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_latency();
    test_flush_pending();
    test_flush_stall();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
